// File: rtl/xm_mem_pkg.sv
// Shared types and constants for the memory access sequencer.
package xm_mem_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Byte-enable patterns: [0] = even byte, [1] = odd byte
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Default wait-state limit when the bus timeout is built in
  localparam int unsigned TIMEOUT_CYCLES_DFLT = 255;

endpackage : xm_mem_pkg

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering for bus writes and read alignment.
module mem_lane_steer
  import xm_mem_pkg::*;
#(
  parameter int unsigned WORD = 16
) (
  input  logic            byte_acc,
  input  logic            addr_lsb,
  input  logic [WORD-1:0] wdata,
  input  logic [WORD-1:0] bus_rdata,
  output logic [1:0]      be_c,
  output logic [WORD-1:0] wdata_c,
  output logic [WORD-1:0] rdata_c
);

  // Word accesses pass straight through; byte accesses replicate/select a lane
  always_comb begin
    be_c    = BE_WORD;
    wdata_c = wdata;
    rdata_c = bus_rdata;
    if (byte_acc) begin
      be_c    = addr_lsb ? BE_HI : BE_LO;
      wdata_c = WORD'({wdata[7:0], wdata[7:0]});
      rdata_c = WORD'(addr_lsb ? bus_rdata[15:8] : bus_rdata[7:0]);
    end
  end

endmodule : mem_lane_steer

// File: rtl/mem_access_ctrl.sv
// Request/acknowledge memory access sequencer between the register file
// and the external memory bus. Optional bus timeout: MEM_TIMEOUT_EN.
module mem_access_ctrl
  import xm_mem_pkg::*;
#(
  parameter int unsigned WORD           = 16,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            we_i,
  input  logic            byte_i,
  input  logic [WORD-1:0] addr_i,
  input  logic [WORD-1:0] wdata_i,
  output logic [WORD-1:0] rdata_o,
  output logic            imdr_wr_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            err_o,
  output logic            mem_cs_o,
  output logic            mem_we_o,
  output logic [WORD-1:0] mem_addr_o,
  output logic [1:0]      mem_be_o,
  output logic [WORD-1:0] mem_wdata_o,
  input  logic [WORD-1:0] mem_rdata_i,
  input  logic            mem_ack_i
);

  // Byte lanes are fixed at 8 bits, so the word must hold two of them
  if (WORD < 16 || (WORD % 2) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("mem_access_ctrl: WORD must be even and >= 16, TIMEOUT_CYCLES > 0");
  end

  state_e          state;
  logic            byte_q;
  logic            addr0_q;
  logic            steer_byte;
  logic            steer_lsb;
  logic [1:0]      be_c;
  logic [WORD-1:0] wdata_c;
  logic [WORD-1:0] rdata_c;

  // In IDLE the steering sees the live request; afterwards the latched one
  assign steer_byte = (state == ST_IDLE) ? byte_i    : byte_q;
  assign steer_lsb  = (state == ST_IDLE) ? addr_i[0] : addr0_q;

  mem_lane_steer #(.WORD(WORD)) u_lane_steer (
    .byte_acc  (steer_byte),
    .addr_lsb  (steer_lsb),
    .wdata     (wdata_i),
    .bus_rdata (mem_rdata_i),
    .be_c      (be_c),
    .wdata_c   (wdata_c),
    .rdata_c   (rdata_c)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      byte_q      <= 1'b0;
      addr0_q     <= 1'b0;
      rdata_o     <= '0;
      imdr_wr_o   <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_cs_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= 2'b00;
      mem_wdata_o <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      imdr_wr_o <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            byte_q  <= byte_i;
            addr0_q <= addr_i[0];
            busy_o  <= 1'b1;
            if (!byte_i && addr_i[0]) begin
              // Misaligned word access: report without touching the bus
              state  <= ST_ERR;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state       <= ST_BUS;
              mem_cs_o    <= 1'b1;
              mem_we_o    <= we_i;
              mem_addr_o  <= {addr_i[WORD-1:1], 1'b0};
              mem_be_o    <= be_c;
              mem_wdata_o <= wdata_c;
`ifdef MEM_TIMEOUT_EN
              wait_cnt    <= '0;
`endif
            end
          end
        end
        ST_BUS: begin
          if (mem_ack_i) begin
            state     <= ST_DONE;
            mem_cs_o  <= 1'b0;
            done_o    <= 1'b1;
            imdr_wr_o <= !mem_we_o;
            if (!mem_we_o) rdata_o <= rdata_c;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Limit reached without ack: abandon the bus cycle
            state    <= ST_ERR;
            mem_cs_o <= 1'b0;
            done_o   <= 1'b1;
            err_o    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        ST_ERR: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: randomized requests against a
// transaction-level model, with a wait-state bus responder.
module tb_mem_access_ctrl;

  localparam int unsigned WORD = 16;
  localparam int TO = 4;

  logic            clk_i;
  logic            rst_i;
  logic            start_i;
  logic            we_i;
  logic            byte_i;
  logic [WORD-1:0] addr_i;
  logic [WORD-1:0] wdata_i;
  logic [WORD-1:0] rdata_o;
  logic            imdr_wr_o;
  logic            done_o;
  logic            busy_o;
  logic            err_o;
  logic            mem_cs_o;
  logic            mem_we_o;
  logic [WORD-1:0] mem_addr_o;
  logic [1:0]      mem_be_o;
  logic [WORD-1:0] mem_wdata_o;
  logic [WORD-1:0] mem_rdata_i;
  logic            mem_ack_i;

  mem_access_ctrl #(.WORD(WORD), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .we_i        (we_i),
    .byte_i      (byte_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .imdr_wr_o   (imdr_wr_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .mem_cs_o    (mem_cs_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic        imdr;
    logic [15:0] rdata;
    int          lat;
    int          t0;
  } comp_exp_t;

  bus_exp_t    bus_q[$];
  comp_exp_t   comp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_rdata = 16'h0000;
  int          rsp_wait = 0;
  logic [15:0] rsp_data = 16'h0000;
  int          bcnt = 0;
  logic        cs_prev = 1'b0;
  bus_exp_t    cur_bus;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Bus responder: ack after rsp_wait wait states, random ack noise outside BUS
  always @(negedge clk_i) begin
    if (mem_cs_o) begin
      if (bcnt >= rsp_wait) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rsp_data;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'($urandom);
        bcnt++;
      end
    end else begin
      bcnt        = 0;
      mem_ack_i   = ($urandom_range(0, 3) == 0);
      mem_rdata_i = 16'($urandom);
    end
  end

  // Monitor: completions, stray strobes, bus request contents and stability
  always @(negedge clk_i) begin
    if (rst_i) begin
      comp_exp_t c;
      if (done_o) begin
        checks++;
        if (comp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d err=%0b rdata=%h", cyc, err_o, rdata_o);
        end else begin
          c = comp_q.pop_front();
          if (err_o !== c.err || imdr_wr_o !== c.imdr || rdata_o !== c.rdata ||
              busy_o !== 1'b1 || (cyc - c.t0) != c.lat) begin
            errors++;
            $display("FAIL completion got err=%0b imdr=%0b rdata=%h busy=%0b lat=%0d want err=%0b imdr=%0b rdata=%h busy=1 lat=%0d",
                     err_o, imdr_wr_o, rdata_o, busy_o, cyc - c.t0, c.err, c.imdr, c.rdata, c.lat);
          end
        end
      end
      checks++;
      if (!done_o && (err_o || imdr_wr_o)) begin
        errors++;
        $display("FAIL stray_strobe got err=%0b imdr=%0b without done, want 0/0", err_o, imdr_wr_o);
      end
      if (mem_cs_o && !cs_prev) begin
        checks++;
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bus got addr=%h we=%0b want no bus cycle", mem_addr_o, mem_we_o);
          cur_bus = '{we: mem_we_o, addr: mem_addr_o, be: mem_be_o, wdata: mem_wdata_o};
        end else begin
          cur_bus = bus_q.pop_front();
        end
      end
      if (mem_cs_o) begin
        checks++;
        if (mem_we_o !== cur_bus.we || mem_addr_o !== cur_bus.addr ||
            mem_be_o !== cur_bus.be || mem_wdata_o !== cur_bus.wdata) begin
          errors++;
          $display("FAIL bus_request got we=%0b addr=%h be=%b wdata=%h want we=%0b addr=%h be=%b wdata=%h",
                   mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                   cur_bus.we, cur_bus.addr, cur_bus.be, cur_bus.wdata);
        end
      end
      cs_prev = mem_cs_o;
    end else begin
      cs_prev = 1'b0;
    end
  end

  // Issue one request; expected results come from the transaction model
  task automatic issue(input logic we, input logic bt, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rd, input int wt);
    logic      misalign;
    logic      timed_out;
    logic      done_seen;
    bus_exp_t  b;
    comp_exp_t c;
    @(negedge clk_i);
    rsp_wait  = wt;
    rsp_data  = rd;
    misalign  = !bt && (addr % 2 == 1);
    timed_out = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timed_out = !misalign && (wt >= TO);
`endif
    if (!misalign) begin
      b.we    = we;
      b.addr  = addr - (addr % 2);
      b.be    = bt ? ((addr % 2 == 1) ? 2'd2 : 2'd1) : 2'd3;
      b.wdata = bt ? 16'((wdata % 256) * 257) : wdata;
      bus_q.push_back(b);
    end
    if (!misalign && !timed_out && !we)
      exp_rdata = bt ? ((addr % 2 == 1) ? rd / 256 : rd % 256) : rd;
    c.err   = misalign || timed_out;
    c.imdr  = !c.err && !we;
    c.rdata = exp_rdata;
    c.lat   = misalign ? 1 : (timed_out ? 1 + TO : 2 + wt);
    c.t0    = cyc;
    comp_q.push_back(c);
    start_i = 1'b1;
    we_i    = we;
    byte_i  = bt;
    addr_i  = addr;
    wdata_i = wdata;
    done_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        done_seen = 1'b1;
        break;
      end
      // Requests while busy must be ignored
      start_i = 1'($urandom_range(0, 1));
      we_i    = 1'($urandom_range(0, 1));
      byte_i  = 1'($urandom_range(0, 1));
      addr_i  = 16'($urandom);
      wdata_i = 16'($urandom);
    end
    start_i = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout addr=%h got no done within 300 cycles want done", addr);
    end
  endtask

  // Reset in the middle of a bus cycle: abandoned, no done pulse
  task automatic reset_in_bus();
    bus_exp_t b;
    @(negedge clk_i);
    rsp_wait = 1000;
    b = '{we: 1'b0, addr: 16'h0300, be: 2'b11, wdata: 16'h1111};
    bus_q.push_back(b);
    start_i = 1'b1; we_i = 1'b0; byte_i = 1'b0; addr_i = 16'h0300; wdata_i = 16'h1111;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (mem_cs_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || rdata_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_in_bus got cs=%0b busy=%0b done=%0b rdata=%h want 0/0/0/0000",
               mem_cs_o, busy_o, done_o, rdata_o);
    end
    exp_rdata = 16'h0000;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; start_i = 1'b0; we_i = 1'b0; byte_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({rdata_o, imdr_wr_o, done_o, busy_o, err_o, mem_cs_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_state got rdata=%h imdr=%0b done=%0b busy=%0b err=%0b cs=%0b we=%0b addr=%h be=%b wdata=%h want all 0",
               rdata_o, imdr_wr_o, done_o, busy_o, err_o, mem_cs_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
    end
    rst_i = 1'b1;

    issue(1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 0);
    issue(1'b0, 1'b1, 16'h0101, 16'h0000, 16'h12AB, 3);
    issue(1'b1, 1'b1, 16'h0200, 16'hFF5A, 16'h7777, 1);
    issue(1'b1, 1'b0, 16'h0003, 16'hCAFE, 16'h0000, 0);
    issue(1'b0, 1'b1, 16'h0400, 16'h0000, 16'h34CD, 2);
    reset_in_bus();
    issue(1'b0, 1'b0, 16'h0500, 16'h0000, 16'hA5C3, 1);
`ifdef MEM_TIMEOUT_EN
    issue(1'b0, 1'b0, 16'h0600, 16'h0000, 16'h9999, 1000);
    issue(1'b0, 1'b0, 16'h0602, 16'h0000, 16'h4242, TO - 1);
`endif
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
            16'($urandom), 16'($urandom), int'($urandom_range(0, 6)));
    end
    repeat (4) @(negedge clk_i);
    checks++;
    if (bus_q.size() != 0 || comp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got bus=%0d comp=%0d pending want 0/0", bus_q.size(), comp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_access_ctrl

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle memory access sequencer between the hidden register file and the external memory bus. The control unit issues a single read or write request, with the address taken from MAR and the write data from OMDR. The block runs a request/acknowledge transaction with unbounded wait states, steers byte lanes, and returns read data with a one-cycle IMDR write strobe. It also reports done, busy and error status back to the control unit.

## Interface
- WORD, 16, data and address width; must be even.
- TIMEOUT_CYCLES, 255, wait-state limit; used only when MEM_TIMEOUT_EN is defined.

- clk_i  in  1  single system clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request strobe; sampled only in IDLE.
- we_i  in  1  1 = write, 0 = read.
- byte_i  in  1  1 = byte access, 0 = word access.
- addr_i  in  WORD  access address (MARdat_o).
- wdata_i  in  WORD  write data (OMDRdat_o); a byte write uses [7:0].
- rdata_o  out  WORD  read result (to IMDRdat_i).
- imdr_wr_o  out  1  one-cycle IMDR load strobe.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  one-cycle error pulse; coincides with done_o.
- mem_cs_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  WORD  bus address with bit 0 forced to 0.
- mem_be_o  out  2  byte enables: [0] = even byte, [1] = odd byte.
- mem_wdata_o  out  WORD  bus write data.
- mem_rdata_i  in  WORD  bus read data; valid with mem_ack_i.
- mem_ack_i  in  1  bus acknowledge.

## Operation
- States: IDLE, BUS, DONE, ERR.
- IDLE, when start_i=1:
  - Latch we_i, byte_i, addr_i and wdata_i.
  - Word access with addr_i[0]=1 goes to ERR. Everything else goes to BUS.
- BUS:
  - mem_cs_o=1. mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o come from the latched values and are held stable until ack.
  - mem_ack_i=1 goes to DONE. For a read, mem_rdata_i is captured on the same edge.
- DONE: done_o=1 and, for reads only, imdr_wr_o=1. Then goes to IDLE.
- ERR: done_o=1 and err_o=1. No bus cycle is issued and rdata_o is unchanged. Then goes to IDLE.
- Byte lanes:
  - Word access: mem_be_o=2'b11; rdata_o = mem_rdata_i.
  - Byte write: wdata[7:0] is replicated to both lanes; mem_be_o=2'b01 if addr[0]=0, else 2'b10.
  - Byte read: rdata_o = {8'h00, selected byte}, where the selected byte is [7:0] when addr[0]=0 and [15:8] when addr[0]=1.
- start_i is ignored while busy_o=1; there is no queuing.
- mem_ack_i is ignored outside BUS.
- Reset (rst_i=0):
  - Immediately forces IDLE.
  - All outputs go to 0; rdata_o goes to 0.
  - A reset during BUS drops mem_cs_o asynchronously. The transaction is abandoned, with no done_o pulse.

## Timing
- With zero wait states, from the edge that samples start_i:
  - Cycle 1 is BUS, with ack present.
  - Cycle 2 is DONE.
- Total latency is therefore 2 cycles, plus N cycles when ack arrives N cycles late.
- Misaligned word access: ERR is in cycle 1, so latency is 1 cycle.
- rdata_o is registered. It is valid from DONE onward and holds until the next read completes.
- A new start_i is accepted in the cycle after DONE or ERR, which is back-to-back at one request per 3 cycles.
- Bus outputs are registered and change only on state entry.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter is cleared on BUS entry and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, the block goes to ERR and mem_cs_o drops.
  - If ack arrives in the same cycle the limit is reached, ack wins.
- MEM_TIMEOUT_EN undefined: there is no counter, and BUS waits indefinitely.

## Structure
- Package xm_mem_pkg holds:
  - the state enum (IDLE, BUS, DONE, ERR);
  - byte-enable constants (BE_WORD, BE_LO, BE_HI);
  - the default TIMEOUT_CYCLES.
- Sub-module mem_lane_steer is combinational. It maps latched byte_i, addr[0] and wdata to mem_be_o and mem_wdata_o, and maps mem_rdata_i to the aligned read word.
- The FSM, latches and timeout counter stay in the top module.

## Test plan
- Word read: addr 0x0100, ack in BUS cycle 1, mem_rdata 0xBEEF. Required: in cycle 2, rdata_o=0xBEEF with imdr_wr_o=1 and done_o=1.
- Byte read: addr 0x0101 with 3 wait states, mem_rdata 0x12AB. Required:
  - mem_be_o=2'b10 and mem_addr_o=0x0100 throughout BUS;
  - rdata_o=0x0012;
  - done_o in cycle 5.
- Byte write: addr 0x0200, wdata 0xFF5A. Required: mem_wdata_o=0x5A5A, mem_be_o=2'b01, mem_we_o=1, imdr_wr_o stays 0.
- Misaligned word write at 0x0003. Required: mem_cs_o never asserts; err_o=1 and done_o=1 in cycle 1.
- Reset: assert rst_i low in BUS. Required: mem_cs_o=0 before the next edge, no done_o, and a following request completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never asserted. Required: err_o pulse after 4 BUS cycles, then return to IDLE.
